// File: rtl/seg_pkg.sv
// Shared constants, segment table and helpers for the six-digit seven-segment display back-end.
package seg_pkg;

  localparam int          DATA_W     = 20;
  localparam int          NUM_DIGITS = 6;
  localparam logic [19:0] MAX_VALUE  = 20'd999999;
  localparam logic [7:0]  SEG_OFF    = 8'hFF;
  localparam logic [5:0]  SEL_OFF    = 6'h3F;

  // {dp,g,f,e,d,c,b,a}, active low, dp off
  localparam logic [7:0] SEG_CODE [0:9] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } conv_state_t;

  function automatic logic [19:0] clamp_value(input logic [19:0] value);
    logic [19:0] result;
    if (value > MAX_VALUE) result = MAX_VALUE;
    else                   result = value;
    return result;
  endfunction

  function automatic logic [7:0] seg_encode(input logic [3:0] digit);
    logic [7:0] code;
    if (digit <= 4'd9) code = SEG_CODE[digit];
    else               code = SEG_OFF;
    return code;
  endfunction

  // Bit i set when digit i and everything above it is zero with no decimal point lit
  function automatic logic [5:0] lead_zero_mask(input logic [23:0] bcd, input logic [5:0] pt);
    logic [5:0] mask;
    logic       run;
    run  = 1'b1;
    mask = 6'd0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run     = run && (bcd[4*i +: 4] == 4'd0) && !pt[i];
      mask[i] = run;
    end
    return mask;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter; restarts a fresh conversion every 22 cycles.
// bcd carries the accumulator and is complete exactly while bcd_valid is high.
module bin2bcd_seq
  import seg_pkg::*;
(
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [19:0] bin,
  output logic [23:0] bcd,
  output logic        bcd_valid
);

  conv_state_t state_r;
  logic [19:0] bin_r;
  logic [23:0] acc_r;
  logic [23:0] adj_s;
  logic [4:0]  cnt_r;
  logic        valid_r;

  // Add 3 to each nibble of 5 or more ahead of the shift
  always_comb begin
    adj_s = acc_r;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (acc_r[4*i +: 4] >= 4'd5) adj_s[4*i +: 4] = acc_r[4*i +: 4] + 4'd3;
      else                         adj_s[4*i +: 4] = acc_r[4*i +: 4];
    end
  end

  // Conversion sequencer: capture, 20 shifts, publish
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r <= IDLE;
      bin_r   <= 20'd0;
      acc_r   <= 24'd0;
      cnt_r   <= 5'd0;
      valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          bin_r   <= clamp_value(bin);
          acc_r   <= 24'd0;
          cnt_r   <= 5'd0;
          valid_r <= 1'b0;
          state_r <= SHIFT;
        end
        SHIFT: begin
          {acc_r, bin_r} <= {adj_s[22:0], bin_r, 1'b0};
          if (cnt_r == 5'd19) begin
            cnt_r   <= 5'd0;
            valid_r <= 1'b1;
            state_r <= LOAD;
          end else begin
            cnt_r   <= cnt_r + 5'd1;
            valid_r <= 1'b0;
          end
        end
        LOAD: begin
          valid_r <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          valid_r <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bcd       = acc_r;
  assign bcd_valid = valid_r;

endmodule

// File: rtl/seg_led_driver.sv
// Six-digit common-anode display driver: BCD conversion, digit scan, leading-zero blanking
// and segment encode, with registered seg_sel/seg_led.
module seg_led_driver
  import seg_pkg::*;
#(
  parameter logic [15:0] CLK_DIV = 16'd50000
)
(
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [19:0] data,
  input  logic [5:0]  point,
  input  logic        en,
  output logic [5:0]  seg_sel,
  output logic [7:0]  seg_led
);

  logic [23:0] bcd_s;
  logic        bcd_valid_s;
  logic [23:0] disp_bcd_r;
  logic [15:0] div_r;
  logic [2:0]  digit_r;
  logic        tick_s;
  logic [5:0]  lz_s;
  logic [3:0]  digit_val_s;
  logic [7:0]  code_s;
  logic        blank_s;
  logic [5:0]  sel_nxt_s;
  logic [7:0]  led_nxt_s;

  bin2bcd_seq u_conv (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bin       (data),
    .bcd       (bcd_s),
    .bcd_valid (bcd_valid_s)
  );

  assign tick_s = (div_r == CLK_DIV - 16'd1);

  // Whole-value update of the displayed digits, only from a finished conversion
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)       disp_bcd_r <= 24'd0;
    else if (bcd_valid_s) disp_bcd_r <= bcd_s;
    else                  disp_bcd_r <= disp_bcd_r;
  end

  // Scan slot divider and digit index
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div_r   <= 16'd0;
      digit_r <= 3'd0;
    end else if (tick_s) begin
      div_r <= 16'd0;
      if (digit_r == 3'd5) digit_r <= 3'd0;
      else                 digit_r <= digit_r + 3'd1;
    end else begin
      div_r   <= div_r + 16'd1;
      digit_r <= digit_r;
    end
  end

  // Next segment/select pattern for the current digit
  always_comb begin
    lz_s        = lead_zero_mask(disp_bcd_r, point);
    digit_val_s = disp_bcd_r[{digit_r, 2'b00} +: 4];
    code_s      = seg_encode(digit_val_s);
    blank_s     = (digit_r != 3'd0) && lz_s[digit_r];
    if (!en) begin
      sel_nxt_s = SEL_OFF;
      led_nxt_s = SEG_OFF;
    end else if (blank_s) begin
      sel_nxt_s = ~(6'd1 << digit_r);
      led_nxt_s = SEG_OFF;
    end else begin
      sel_nxt_s = ~(6'd1 << digit_r);
      led_nxt_s = {~point[digit_r], code_s[6:0]};
    end
  end

  // Registered display outputs
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      seg_sel <= SEL_OFF;
      seg_led <= SEG_OFF;
    end else begin
      seg_sel <= sel_nxt_s;
      seg_led <= led_nxt_s;
    end
  end

endmodule
